// File: rtl/sm_key_input.sv
// Conditions raw push-buttons/switches into debounced levels, press/release
// edge pulses and optional auto-repeat pulses, one independent channel per bit.
module sm_key_input #(
    parameter int WIDTH           = 2,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] pressed_o,
    output logic [WIDTH-1:0] press_o,
    output logic [WIDTH-1:0] release_o,
    output logic [WIDTH-1:0] repeat_o,
    output logic [WIDTH-1:0] step_o
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] POL_MASK = {WIDTH{ACTIVE_LOW}};
    localparam bit               REPEAT_EN = (REPEAT_DELAY > 0) && (REPEAT_PERIOD >= 1);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;

    // Two-flop synchronizer; the stored level is already normalised (1 = pressed).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= {WIDTH{1'b0}};
            s2_r <= {WIDTH{1'b0}};
        end else begin
            s1_r <= raw_i ^ POL_MASK;
            s2_r <= s1_r;
        end
    end

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt_r;
        logic             pressed_r;
        logic             press_r;
        logic             release_r;
        logic             differ_s;
        logic             accept_s;
        logic             repeat_s;

        assign differ_s = s2_r[ch] ^ pressed_r;
        assign accept_s = differ_s && (cnt_r == CNT_LAST);

        // Debounce counter plus registered level and edge pulses.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r     <= {CNT_W{1'b0}};
                pressed_r <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else if (!differ_s) begin
                cnt_r     <= {CNT_W{1'b0}};
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else if (accept_s) begin
                cnt_r     <= {CNT_W{1'b0}};
                pressed_r <= s2_r[ch];
                press_r   <= s2_r[ch];
                release_r <= ~s2_r[ch];
            end else begin
                cnt_r     <= cnt_r + CNT_W'(1'b1);
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end
        end

        if (REPEAT_EN) begin : g_rep
            localparam int RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
            localparam int RCNT_W = $clog2(RMAX + 1);
            localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
            localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

            typedef enum logic [1:0] {
                ST_IDLE   = 2'd0,
                ST_DELAY  = 2'd1,
                ST_PERIOD = 2'd2
            } rep_state_e;

            rep_state_e        state_r;
            rep_state_e        state_nxt_s;
            logic [RCNT_W-1:0] rcnt_r;
            logic [RCNT_W-1:0] rcnt_nxt_s;
            logic              rise_s;
            logic              fall_s;
            logic              fire_s;
            logic              repeat_r;

            // The FSM reacts at the same edge the debounced level changes.
            assign rise_s = accept_s & s2_r[ch];
            assign fall_s = accept_s & ~s2_r[ch];

            // Repeat state, counter and registered repeat pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_r  <= ST_IDLE;
                    rcnt_r   <= {RCNT_W{1'b0}};
                    repeat_r <= 1'b0;
                end else begin
                    state_r  <= state_nxt_s;
                    rcnt_r   <= rcnt_nxt_s;
                    repeat_r <= fire_s;
                end
            end

            // Next-state and counter update; a debounced release always wins.
            always_comb begin
                state_nxt_s = state_r;
                rcnt_nxt_s  = {RCNT_W{1'b0}};
                if (fall_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            if (rise_s) begin
                                state_nxt_s = ST_DELAY;
                            end else begin
                                state_nxt_s = ST_IDLE;
                            end
                        end
                        ST_DELAY: begin
                            if (rcnt_r == DELAY_LAST) begin
                                state_nxt_s = ST_PERIOD;
                            end else begin
                                rcnt_nxt_s = rcnt_r + RCNT_W'(1'b1);
                            end
                        end
                        ST_PERIOD: begin
                            if (rcnt_r == PERIOD_LAST) begin
                                rcnt_nxt_s = {RCNT_W{1'b0}};
                            end else begin
                                rcnt_nxt_s = rcnt_r + RCNT_W'(1'b1);
                            end
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end
            end

            // Repeat pulse request, suppressed in the cycle of a release.
            always_comb begin
                fire_s = 1'b0;
                if (fall_s) begin
                    fire_s = 1'b0;
                end else begin
                    case (state_r)
                        ST_DELAY:  fire_s = (rcnt_r == DELAY_LAST);
                        ST_PERIOD: fire_s = (rcnt_r == PERIOD_LAST);
                        default:   fire_s = 1'b0;
                    endcase
                end
            end

            assign repeat_s = repeat_r;
        end else begin : g_norep
            assign repeat_s = 1'b0;
        end

        assign pressed_o[ch] = pressed_r;
        assign press_o[ch]   = press_r;
        assign release_o[ch] = release_r;
        assign repeat_o[ch]  = repeat_s;
    end

    assign step_o = press_o | repeat_o;

endmodule

// File: tb/tb_sm_key_input.sv
// Scoreboard bench for sm_key_input with D=4, R=10, P=3, two active-low channels.
module tb_sm_key_input;

    localparam int W = 2;
    localparam int K_PRESS = 0, K_RELEASE = 1, K_REPEAT = 2, K_STEP = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] raw_i;
    logic [W-1:0] pressed_o, press_o, release_o, repeat_o, step_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    ev_t exp_q[$];

    sm_key_input #(
        .WIDTH          (2),
        .ACTIVE_LOW     (1'b1),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (raw_i),
        .pressed_o(pressed_o),
        .press_o  (press_o),
        .release_o(release_o),
        .repeat_o (repeat_o),
        .step_o   (step_o)
    );

    always #5 clk = ~clk;

    // Count rising edges; at a falling edge cyc equals the number of edges seen.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_REPEAT:  return "repeat";
            default:   return "step";
        endcase
    endfunction

    // Expected pulse at falling edge c; press and repeat also show on step_o.
    task automatic push_ev(input int c, input int ch, input int kind);
        ev_t e;
        e.cyc = c; e.ch = ch; e.kind = kind;
        exp_q.push_back(e);
        if (kind == K_PRESS || kind == K_REPEAT) begin
            e.kind = K_STEP;
            exp_q.push_back(e);
        end
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard: every observed pulse must match a queued expectation, and
    // every expectation must be seen by its cycle.
    always @(negedge clk) begin
        for (int ch = 0; ch < W; ch++) begin
            for (int k = 0; k < 4; k++) begin
                logic b;
                int   idx;
                b   = (k == K_PRESS) ? press_o[ch] : (k == K_RELEASE) ? release_o[ch] :
                      (k == K_REPEAT) ? repeat_o[ch] : step_o[ch];
                idx = -1;
                if (b === 1'b1) begin
                    foreach (exp_q[i])
                        if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].ch == ch && exp_q[i].kind == k)
                            idx = i;
                    vectors++;
                    if (idx < 0) begin
                        miscompares++;
                        $display("FAIL unexpected_%s ch%0d: pulse seen at cycle %0d, required no pulse",
                                 kname(k), ch, cyc);
                    end else begin
                        exp_q.delete(idx);
                    end
                end
            end
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missing_%s ch%0d: no pulse at cycle %0d, required pulse there",
                         kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
                exp_q.delete(i);
            end
        end
    end

    task automatic test_reset();
        int k, k2;
        rst   = 1'b1;
        raw_i = 2'b00;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({pressed_o, press_o, release_o, repeat_o, step_o} !== 10'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %b, required 0",
                         {pressed_o, press_o, release_o, repeat_o, step_o});
            end
        end
        rst = 1'b0;
        k   = cyc + 1;
        push_ev(k + 5, 0, K_PRESS);
        push_ev(k + 5, 1, K_PRESS);
        to_cyc(k + 4);
        vectors++;
        if (pressed_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_early_level: pressed_o=%b, required 00", pressed_o);
        end
        to_cyc(k + 5);
        vectors++;
        if (pressed_o !== 2'b11 || press_o !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_accept: pressed_o=%b press_o=%b, required 11/11", pressed_o, press_o);
        end
        raw_i = 2'b11;
        k2    = cyc + 1;
        push_ev(k2 + 5, 0, K_RELEASE);
        push_ev(k2 + 5, 1, K_RELEASE);
        to_cyc(k2 + 6);
        vectors++;
        if (pressed_o !== 2'b00 || release_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: pressed_o=%b release_o=%b, required 00/00", pressed_o, release_o);
        end
    endtask

    task automatic test_press();
        int k, k2;
        raw_i = 2'b10;
        k     = cyc + 1;
        push_ev(k + 5, 0, K_PRESS);
        to_cyc(k + 4);
        vectors++;
        if (pressed_o !== 2'b00) begin
            miscompares++;
            $display("FAIL press_early: pressed_o=%b at k+4, required 00", pressed_o);
        end
        to_cyc(k + 5);
        vectors++;
        if (pressed_o !== 2'b01 || press_o !== 2'b01) begin
            miscompares++;
            $display("FAIL press_accept: pressed_o=%b press_o=%b, required 01/01", pressed_o, press_o);
        end
        to_cyc(k + 6);
        vectors++;
        if (pressed_o !== 2'b01 || press_o !== 2'b00) begin
            miscompares++;
            $display("FAIL press_one_cycle: pressed_o=%b press_o=%b, required 01/00", pressed_o, press_o);
        end
        raw_i = 2'b11;
        k2    = cyc + 1;
        push_ev(k2 + 5, 0, K_RELEASE);
        to_cyc(k2 + 6);
    endtask

    task automatic test_glitch();
        int           c;
        logic [9:0]   pat;
        c     = cyc;
        raw_i = 2'b10;
        to_cyc(c + 3);
        raw_i = 2'b11;
        to_cyc(c + 12);
        vectors++;
        if (pressed_o !== 2'b00) begin
            miscompares++;
            $display("FAIL glitch_3cyc: pressed_o=%b, required 00", pressed_o);
        end
        pat = 10'b1001010010;
        for (int i = 0; i < 10; i++) begin
            raw_i = {1'b1, pat[i]};
            @(negedge clk);
        end
        raw_i = 2'b11;
        to_cyc(cyc + 10);
        vectors++;
        if (pressed_o !== 2'b00) begin
            miscompares++;
            $display("FAIL glitch_chatter: pressed_o=%b, required 00", pressed_o);
        end
    endtask

    task automatic test_repeat();
        int p0;
        raw_i = 2'b10;
        p0    = cyc + 1 + 5;
        push_ev(p0, 0, K_PRESS);
        for (int n = 0; n < 9; n++) push_ev(p0 + 10 + 3 * n, 0, K_REPEAT);
        to_cyc(p0 + 10);
        vectors++;
        if (repeat_o !== 2'b01 || step_o !== 2'b01) begin
            miscompares++;
            $display("FAIL repeat_first: repeat_o=%b step_o=%b, required 01/01", repeat_o, step_o);
        end
        to_cyc(p0 + 11);
        vectors++;
        if (repeat_o !== 2'b00) begin
            miscompares++;
            $display("FAIL repeat_one_cycle: repeat_o=%b, required 00", repeat_o);
        end
        // Release lands exactly where the next repeat would have fired.
        to_cyc(p0 + 31);
        raw_i = 2'b11;
        push_ev(p0 + 37, 0, K_RELEASE);
        to_cyc(p0 + 37);
        vectors++;
        if (release_o !== 2'b01 || repeat_o !== 2'b00) begin
            miscompares++;
            $display("FAIL repeat_release: release_o=%b repeat_o=%b, required 01/00", release_o, repeat_o);
        end
        to_cyc(p0 + 50);
        vectors++;
        if (pressed_o !== 2'b00) begin
            miscompares++;
            $display("FAIL repeat_after: pressed_o=%b, required 00", pressed_o);
        end
    endtask

    task automatic test_channels();
        int c;
        c     = cyc;
        raw_i = 2'b10;
        push_ev(c + 6, 0, K_PRESS);
        to_cyc(c + 6);
        raw_i = 2'b01;
        push_ev(c + 12, 1, K_PRESS);
        push_ev(c + 12, 0, K_RELEASE);
        to_cyc(c + 12);
        vectors++;
        if (press_o !== 2'b10 || release_o !== 2'b01 || pressed_o !== 2'b10) begin
            miscompares++;
            $display("FAIL channels_swap: press_o=%b release_o=%b pressed_o=%b, required 10/01/10",
                     press_o, release_o, pressed_o);
        end
        raw_i = 2'b11;
        push_ev(c + 18, 1, K_RELEASE);
        to_cyc(c + 19);
        vectors++;
        if (pressed_o !== 2'b00) begin
            miscompares++;
            $display("FAIL channels_release: pressed_o=%b, required 00", pressed_o);
        end
    endtask

    task automatic test_reset_mid();
        int k, p;
        raw_i = 2'b10;
        k     = cyc + 1;
        to_cyc(k + 3);
        rst = 1'b1;
        to_cyc(k + 4);
        vectors++;
        if ({pressed_o, press_o, release_o, repeat_o, step_o} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_mid_debounce: got %b, required 0",
                     {pressed_o, press_o, release_o, repeat_o, step_o});
        end
        to_cyc(k + 5);
        rst = 1'b0;
        p   = k + 11;
        push_ev(p, 0, K_PRESS);
        push_ev(p + 10, 0, K_REPEAT);
        to_cyc(p + 11);
        rst = 1'b1;
        to_cyc(p + 12);
        vectors++;
        if (pressed_o !== 2'b00 || repeat_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_mid_period: pressed_o=%b repeat_o=%b, required 00/00", pressed_o, repeat_o);
        end
        to_cyc(p + 13);
        rst = 1'b0;
        push_ev(p + 19, 0, K_PRESS);
        to_cyc(p + 19);
        vectors++;
        if (pressed_o !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_redebounce: pressed_o=%b, required 01", pressed_o);
        end
        raw_i = 2'b11;
        push_ev(p + 25, 0, K_RELEASE);
        to_cyc(p + 30);
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_channels();
        test_reset_mid();
        to_cyc(cyc + 5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expectations: %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
